// File: rtl/facto_pkg.sv
// facto_pkg: shared constants and types for the FactoCore register bank and factorial sequencer
package facto_pkg;
  localparam logic [7:0] ADDR_OPSTART  = 8'h00;
  localparam logic [7:0] ADDR_OPCLEAR  = 8'h08;
  localparam logic [7:0] ADDR_OPDONE   = 8'h10;
  localparam logic [7:0] ADDR_INTREN   = 8'h18;
  localparam logic [7:0] ADDR_OPERAND  = 8'h20;
  localparam logic [7:0] ADDR_RESULT_H = 8'h28;
  localparam logic [7:0] ADDR_RESULT_L = 8'h30;
  localparam int OPDONE_DONE = 0;
  localparam int OPDONE_BUSY = 1;
  localparam int OPDONE_OVF  = 2;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/facto_mul.sv
// facto_mul: combinational 128x64 multiply returning the low 128 bits and an overflow flag
//   a   : 128-bit multiplicand (running result)
//   b   : 64-bit multiplier (counter)
//   p   : low 128 bits of a*b
//   ovf : any product bit above 127 is set
module facto_mul (
  input  logic [127:0] a,
  input  logic [63:0]  b,
  output logic [127:0] p,
  output logic         ovf
);
  logic [191:0] full;
  assign full = {64'd0, a} * {128'd0, b};
  assign p    = full[127:0];
  assign ovf  = |full[191:128];
endmodule

// File: rtl/facto_reg_ctrl.sv
// facto_reg_ctrl: FactoCore register bank and iterative factorial sequencer
//   clk, reset_n            : clock, async active-low reset
//   S_sel, S_wr, S_address,
//   S_din                   : bus write port (write when S_sel & S_wr)
//   from_reg0..from_reg6    : OPSTART, OPCLEAR, OPDONE, INTREN, OPERAND, RESULT_H, RESULT_L images
//   interrupt               : registered OPDONE[0] & INTREN[0]
//   Optional macro FACTO_OVERFLOW_EN adds sticky overflow flag OPDONE[2].
module facto_reg_ctrl
  import facto_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        S_sel,
  input  logic        S_wr,
  input  logic [7:0]  S_address,
  input  logic [63:0] S_din,
  output logic [63:0] from_reg0,
  output logic [63:0] from_reg1,
  output logic [63:0] from_reg2,
  output logic [63:0] from_reg3,
  output logic [63:0] from_reg4,
  output logic [63:0] from_reg5,
  output logic [63:0] from_reg6,
  output logic        interrupt
);
  state_t state, state_nx;
  logic [63:0] opstart, opclear, intren, operand, counter, res_h, res_l;
  logic [127:0] prod;
  logic done, wr, clr, start, fin, step, ovf_bit;
  assign wr    = S_sel & S_wr;
  assign clr   = wr & (S_address == ADDR_OPCLEAR) & S_din[0];
  assign start = wr & (S_address == ADDR_OPSTART) & S_din[0] & (state == IDLE);
  assign fin   = (state == CALC) & (counter <= 64'd1);
  assign step  = (state == CALC) & (counter > 64'd1);
`ifdef FACTO_OVERFLOW_EN
  logic mul_ovf, ovf_q;
  facto_mul u_mul (.a({res_h, res_l}), .b(counter), .p(prod), .ovf(mul_ovf));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ovf_q <= 1'b0;
    else ovf_q <= clr ? 1'b0 : ovf_q | (step & mul_ovf);
  assign ovf_bit = ovf_q;
`else
  facto_mul u_mul (.a({res_h, res_l}), .b(counter), .p(prod), .ovf());
  assign ovf_bit = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    state_nx = clr ? IDLE : start ? CALC : fin ? DONE : state;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opstart   <= '0;
      opclear   <= '0;
      intren    <= '0;
      operand   <= '0;
      counter   <= '0;
      res_h     <= '0;
      res_l     <= '0;
      done      <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      interrupt <= clr ? 1'b0 : done & intren[0];
      if (wr && S_address == ADDR_OPCLEAR) opclear <= S_din;
      if (wr && S_address == ADDR_INTREN) intren <= S_din;
      if (clr) begin
        opstart <= '0;
        counter <= '0;
        res_h   <= '0;
        res_l   <= '0;
        done    <= 1'b0;
      end else begin
        // OPSTART and OPERAND only accept writes while idle
        if (state == IDLE && wr && S_address == ADDR_OPSTART) opstart <= S_din;
        if (state == IDLE && wr && S_address == ADDR_OPERAND) operand <= S_din;
        if (start) begin
          counter <= operand;
          res_h   <= '0;
          res_l   <= 64'd1;
        end
        if (step) begin
          {res_h, res_l} <= prod;
          counter        <= counter - 64'd1;
        end
        if (fin) done <= 1'b1;
      end
    end
  end
  assign from_reg0 = opstart;
  assign from_reg1 = opclear;
  assign from_reg2 = {61'd0, ovf_bit, state == CALC, done};
  assign from_reg3 = intren;
  assign from_reg4 = operand;
  assign from_reg5 = res_h;
  assign from_reg6 = res_l;
endmodule

// File: tb/tb_facto_reg_ctrl.sv
// tb_facto_reg_ctrl: directed self-checking bench for facto_reg_ctrl
module tb_facto_reg_ctrl;
  logic clk = 0, reset_n = 0, S_sel = 0, S_wr = 0;
  logic [7:0] S_address = 0;
  logic [63:0] S_din = 0;
  logic [63:0] from_reg0, from_reg1, from_reg2, from_reg3, from_reg4, from_reg5, from_reg6;
  logic interrupt;
  int n_cmp = 0, n_bad = 0;

  facto_reg_ctrl dut (
    .clk(clk), .reset_n(reset_n), .S_sel(S_sel), .S_wr(S_wr), .S_address(S_address),
    .S_din(S_din), .from_reg0(from_reg0), .from_reg1(from_reg1), .from_reg2(from_reg2),
    .from_reg3(from_reg3), .from_reg4(from_reg4), .from_reg5(from_reg5),
    .from_reg6(from_reg6), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [7:0] a, input logic [63:0] d, input logic sel = 1'b1);
    @(negedge clk);
    S_sel = sel; S_wr = 1'b1; S_address = a; S_din = d;
    @(posedge clk);
    #1;
    S_sel = 1'b0; S_wr = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 0;
    #12;
    n_cmp++; if ({from_reg0, from_reg1, from_reg2, from_reg3, from_reg4, from_reg5, from_reg6, interrupt} !== '0) begin
      n_bad++; $display("FAIL reset_zero got r2=%h r6=%h irq=%b want all 0", from_reg2, from_reg6, interrupt); end
    @(negedge clk); reset_n = 1;
    tick(1);
    n_cmp++; if (from_reg2 !== 64'h0) begin n_bad++; $display("FAIL reset_idle got %h want 0", from_reg2); end
  endtask

  task automatic test_fact5;
    write(8'h20, 64'd5);
    write(8'h18, 64'd1);
    write(8'h00, 64'd1);
    tick(4);
    n_cmp++; if (from_reg2 !== 64'h2) begin n_bad++; $display("FAIL f5_busy got %h want 2", from_reg2); end
    tick(1);
    n_cmp++; if (from_reg2 !== 64'h1) begin n_bad++; $display("FAIL f5_opdone got %h want 1", from_reg2); end
    n_cmp++; if (from_reg5 !== 64'h0) begin n_bad++; $display("FAIL f5_res_h got %h want 0", from_reg5); end
    n_cmp++; if (from_reg6 !== 64'h78) begin n_bad++; $display("FAIL f5_res_l got %h want 78", from_reg6); end
    n_cmp++; if (interrupt !== 1'b0) begin n_bad++; $display("FAIL f5_irq_early got %b want 0", interrupt); end
    tick(1);
    n_cmp++; if (interrupt !== 1'b1) begin n_bad++; $display("FAIL f5_irq got %b want 1", interrupt); end
    n_cmp++; if (from_reg0 !== 64'h1 || from_reg3 !== 64'h1 || from_reg4 !== 64'h5) begin n_bad++;
      $display("FAIL f5_regs got %h %h %h want 1 1 5", from_reg0, from_reg3, from_reg4); end
  endtask

  task automatic test_ignored_writes;
    write(8'h30, 64'hDEAD);
    write(8'h28, 64'hBEEF);
    write(8'h10, 64'h0);
    write(8'h38, 64'h1);
    write(8'h00, 64'h3);
    write(8'h20, 64'h9, 1'b0);
    n_cmp++; if (from_reg6 !== 64'h78 || from_reg5 !== 64'h0 || from_reg2 !== 64'h1) begin n_bad++;
      $display("FAIL ro_writes got %h %h %h want 78 0 1", from_reg6, from_reg5, from_reg2); end
    n_cmp++; if (from_reg0 !== 64'h1 || from_reg4 !== 64'h5) begin n_bad++;
      $display("FAIL done_start_ignored got %h %h want 1 5", from_reg0, from_reg4); end
  endtask

  task automatic test_clear;
    write(8'h08, 64'h5);
    n_cmp++; if (from_reg2 !== 64'h0 || from_reg6 !== 64'h0 || from_reg0 !== 64'h0 || interrupt !== 1'b0) begin n_bad++;
      $display("FAIL clear got r2=%h r6=%h r0=%h irq=%b want 0", from_reg2, from_reg6, from_reg0, interrupt); end
    n_cmp++; if (from_reg1 !== 64'h5 || from_reg3 !== 64'h1 || from_reg4 !== 64'h5) begin n_bad++;
      $display("FAIL clear_keep got %h %h %h want 5 1 5", from_reg1, from_reg3, from_reg4); end
  endtask

  task automatic test_fact21;
    write(8'h18, 64'd0);
    write(8'h20, 64'd21);
    write(8'h00, 64'd1);
    tick(25);
    n_cmp++; if (from_reg5 !== 64'h2) begin n_bad++; $display("FAIL f21_res_h got %h want 2", from_reg5); end
    n_cmp++; if (from_reg6 !== 64'hC5077D36B8C40000) begin n_bad++;
      $display("FAIL f21_res_l got %h want c5077d36b8c40000", from_reg6); end
    n_cmp++; if (interrupt !== 1'b0) begin n_bad++; $display("FAIL f21_irq got %b want 0", interrupt); end
    write(8'h18, 64'd1);
    n_cmp++; if (interrupt !== 1'b0) begin n_bad++; $display("FAIL intren_irq_early got %b want 0", interrupt); end
    tick(1);
    n_cmp++; if (interrupt !== 1'b1) begin n_bad++; $display("FAIL intren_irq got %b want 1", interrupt); end
    write(8'h08, 64'h1);
    write(8'h18, 64'd0);
  endtask

  task automatic test_small;
    for (int n = 0; n < 2; n++) begin
      write(8'h20, 64'(n));
      write(8'h00, 64'd1);
      tick(1);
      n_cmp++; if (from_reg6 !== 64'h1 || from_reg5 !== 64'h0 || from_reg2 !== 64'h1) begin n_bad++;
        $display("FAIL small_n%0d got %h %h %h want 1 0 1", n, from_reg6, from_reg5, from_reg2); end
      write(8'h08, 64'h1);
    end
  endtask

  task automatic test_abort;
    write(8'h20, 64'd20);
    write(8'h00, 64'd1);
    tick(2);
    write(8'h08, 64'h1);
    n_cmp++; if (from_reg2 !== 64'h0 || from_reg5 !== 64'h0 || from_reg6 !== 64'h0) begin n_bad++;
      $display("FAIL abort got %h %h %h want 0 0 0", from_reg2, from_reg5, from_reg6); end
    n_cmp++; if (from_reg4 !== 64'd20) begin n_bad++; $display("FAIL abort_operand got %h want 14", from_reg4); end
    tick(3);
    n_cmp++; if (from_reg2 !== 64'h0 || from_reg6 !== 64'h0) begin n_bad++;
      $display("FAIL abort_idle got %h %h want 0 0", from_reg2, from_reg6); end
  endtask

  task automatic test_busy_writes;
    write(8'h20, 64'd4);
    write(8'h00, 64'd1);
    write(8'h20, 64'd7);
    write(8'h00, 64'd3);
    n_cmp++; if (from_reg4 !== 64'd4 || from_reg0 !== 64'd1) begin n_bad++;
      $display("FAIL busy_regs got %h %h want 4 1", from_reg4, from_reg0); end
    tick(1);
    n_cmp++; if (from_reg2 !== 64'h2) begin n_bad++; $display("FAIL busy_state got %h want 2", from_reg2); end
    tick(1);
    n_cmp++; if (from_reg6 !== 64'd24 || from_reg2 !== 64'h1) begin n_bad++;
      $display("FAIL busy_result got %h %h want 18 1", from_reg6, from_reg2); end
    write(8'h08, 64'h1);
  endtask

  task automatic test_overflow;
    write(8'h20, 64'd40);
    write(8'h00, 64'd1);
    tick(45);
`ifdef FACTO_OVERFLOW_EN
    n_cmp++; if (from_reg2 !== 64'h5) begin n_bad++; $display("FAIL ovf40 got %h want 5", from_reg2); end
    write(8'h08, 64'h1);
    n_cmp++; if (from_reg2 !== 64'h0) begin n_bad++; $display("FAIL ovf_clear got %h want 0", from_reg2); end
`else
    n_cmp++; if (from_reg2 !== 64'h1) begin n_bad++; $display("FAIL ovf40 got %h want 1", from_reg2); end
    write(8'h08, 64'h1);
`endif
  endtask

  task automatic test_reset_mid;
    write(8'h18, 64'd1);
    write(8'h20, 64'd20);
    write(8'h00, 64'd1);
    tick(3);
    #2 reset_n = 0;
    #1;
    n_cmp++; if ({from_reg0, from_reg2, from_reg3, from_reg4, from_reg5, from_reg6, interrupt} !== '0) begin n_bad++;
      $display("FAIL reset_mid got r2=%h r4=%h r6=%h irq=%b want 0", from_reg2, from_reg4, from_reg6, interrupt); end
    @(negedge clk); reset_n = 1;
    tick(2);
    n_cmp++; if (from_reg2 !== 64'h0 || from_reg6 !== 64'h0) begin n_bad++;
      $display("FAIL reset_mid_idle got %h %h want 0 0", from_reg2, from_reg6); end
  endtask

  initial begin
    test_reset;
    test_fact5;
    test_ignored_writes;
    test_clear;
    test_fact21;
    test_small;
    test_abort;
    test_busy_writes;
    test_overflow;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/facto_reg_ctrl.md
# facto_reg_ctrl

Register bank and factorial sequencer for FactoCore, sitting directly upstream of the 7-to-1 read mux. It decodes bus writes to the core's control registers, runs an iterative factorial on the 64-bit operand, and drives the seven 64-bit register images (`from_reg0`–`from_reg6`) that the read path selects by `S_address`. It also raises the core interrupt.

## Interface
Parameters:
- None. Widths are fixed: data 64, address 8.

Ports:
- `clk`: in, 1. Single clock, rising edge.
- `reset_n`: in, 1. Asynchronous, active-low reset.
- `S_sel`: in, 1. Slave select.
- `S_wr`: in, 1. Write strobe; a write occurs when `S_sel & S_wr` at a clock edge.
- `S_address`: in, 8. Byte offset of the register.
- `S_din`: in, 64. Write data.
- `from_reg0`: out, 64. OPSTART image (offset 0x00).
- `from_reg1`: out, 64. OPCLEAR image (offset 0x08).
- `from_reg2`: out, 64. OPDONE image (offset 0x10).
- `from_reg3`: out, 64. INTREN image (offset 0x18).
- `from_reg4`: out, 64. OPERAND image (offset 0x20).
- `from_reg5`: out, 64. RESULT_H image (offset 0x28).
- `from_reg6`: out, 64. RESULT_L image (offset 0x30).
- `interrupt`: out, 1. `OPDONE[0] & INTREN[0]`, registered.

## Operation
- **Reset:** every output is 0, the state is IDLE, and the counter is 0.
- **Writable registers:** OPSTART, OPCLEAR, INTREN and OPERAND latch the full `S_din` on a write.
  - OPDONE, RESULT_H and RESULT_L are read-only; writes to them are ignored.
  - Writes to unmapped offsets are ignored.
- **OPCLEAR:** a write with `S_din[0]=1` forces IDLE and zeroes OPSTART, OPDONE, RESULT_H, RESULT_L and `interrupt`.
  - The OPCLEAR register keeps the written value.
  - OPERAND and INTREN are preserved.
  - OPCLEAR has priority over every other event, including a mid-computation run.
- **Start:** a write to OPSTART with `S_din[0]=1` while in IDLE causes:
  - state to CALC;
  - {RESULT_H, RESULT_L} to 1;
  - counter to OPERAND.
- **Ignored while busy:** in CALC or DONE, writes to OPSTART and OPERAND are dropped, so the registers are unchanged.
- **CALC step:** each cycle,
  - if counter ≤ 1: go to DONE and set OPDONE[0]=1;
  - else: {H,L} ← low 128 bits of ({H,L} × counter), and counter ← counter − 1.
- **DONE:** held until OPCLEAR. A start write in DONE is ignored.
- **OPDONE layout:** bit0 = done, bit1 = busy (state==CALC), bits 63:2 = 0 (see Configuration for bit2).
- **Width rule:** the product is truncated to 128 bits, so results for N ≥ 35 wrap silently.

## Timing
- The start write is accepted at edge E0, and the state is CALC after E0.
- DONE is entered at edge E(max(N,1)).
  - OPDONE[0], RESULT_H and RESULT_L are final after that edge.
  - `interrupt` rises one edge later, if enabled.
- Examples: N=5 gives DONE after E5; N=0 or 1 gives DONE after E1 with result 1.
- `from_reg*` are register outputs with no combinational path from `S_*`. A write is visible the cycle after its edge.
- An INTREN write while in DONE updates `interrupt` on the following edge.
- OPCLEAR and start in the same cycle cannot occur, because there is one address per cycle.
- OPCLEAR during CALC aborts at that edge, and no partial result is kept.
- An asynchronous reset mid-CALC drives all outputs to 0 immediately.

## Configuration
- **`FACTO_OVERFLOW_EN` defined:** adds a sticky OPDONE[2].
  - It is set when any CALC multiply produces nonzero bits above 127.
  - It is cleared by OPCLEAR or reset.
- **Not defined:** OPDONE[2] is constant 0 and no overflow logic is built.

## Structure
- **Package `facto_pkg`:**
  - address constants `ADDR_OPSTART`…`ADDR_RESULT_L`;
  - state enum `{IDLE, CALC, DONE}`;
  - OPDONE bit indices.
- **Sub-module `facto_mul`:** combinational 128×64 multiply.
  - Outputs the low 128 bits of the product.
  - Outputs an `ovf` flag that is used only under `FACTO_OVERFLOW_EN`.

## Test plan
- **Reset:** assert `reset_n`=0 mid-CALC. All `from_reg*` and `interrupt` go to 0 immediately; after release, state is IDLE.
- **5!:** OPERAND=5, INTREN=1, OPSTART=1.
  - After 5 edges: OPDONE=0x1, RESULT_H=0, RESULT_L=0x78.
  - `interrupt`=1 one edge later.
- **21!:** OPERAND=21, start. Result: RESULT_H=0x2, RESULT_L=0xC5077D36B8C40000, `interrupt` stays 0 with INTREN=0.
- **N=0:** OPERAND=0, start. After 1 edge: RESULT_L=1, OPDONE=0x1.
- **Abort:** OPERAND=20, start, OPCLEAR=1 after 3 edges. Result: OPDONE=0, RESULT=0, state IDLE, OPERAND still 20.
- **Busy writes:** during CALC, write OPERAND=7 and OPSTART=1. Both are ignored and the run completes with the original operand. With `FACTO_OVERFLOW_EN`, OPERAND=40 sets OPDONE[2]=1.
